// File: rtl/nios_system_loader_pkg.sv
// Shared types and constants for the byte-stream loader.
//   state_e        : loader FSM states
//   DEFAULT_ADDR_W : default memory word-address width (8192-word memory)
//   DEFAULT_LEN_W  : default byte-count width
//   BE_LOW/BE_BOTH : byteenable patterns for a lone low byte / a full word
package nios_system_loader_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 13;
    localparam int unsigned DEFAULT_LEN_W  = 15;

    localparam logic [1:0] BE_LOW  = 2'b01;
    localparam logic [1:0] BE_BOTH = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        WRITE,
        DONE
    } state_e;

endpackage

// File: rtl/nios_system_byte_stream_loader.sv
// Avalon-ST byte stream to Avalon-MM write master. Packs byte pairs
// little-endian into 16-bit words and writes them to consecutive word
// addresses, wrapping at the top of the memory. An odd trailing byte is
// written alone with the upper lane zeroed and byteenable = BE_LOW.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   start, start_addr,
//   length             : transfer request (sampled only while idle)
//   in_data, in_valid,
//   in_ready           : byte stream sink
//   mem_*              : single-cycle write master
//   busy, done         : status (done pulses one cycle at the end)
module nios_system_byte_stream_loader
    import nios_system_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned LEN_W  = DEFAULT_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [1:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [15:0]       mem_writedata,
    output logic              busy,
    output logic              done
);

    state_e             state_q,    state_d;
    logic [ADDR_W-1:0]  addr_q,     addr_d;
    logic [LEN_W-1:0]   rem_q,      rem_d;
    logic [7:0]         lo_q,       lo_d;
    logic               in_ready_q, in_ready_d;
    logic               wr_q,       wr_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic [ADDR_W-1:0]  maddr_q,    maddr_d;
    logic [1:0]         be_q,       be_d;
    logic [15:0]        wdata_q,    wdata_d;
    logic               accept;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        lo_d    = lo_q;
        maddr_d = maddr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        accept  = in_valid && in_ready_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = start_addr;
                        rem_d   = length;
                        state_d = LOW;
                    end
                end
            end
            LOW: begin
                if (accept) begin
                    if (rem_q == LEN_W'(1)) begin
                        wdata_d = {8'h00, in_data};
                        be_d    = BE_LOW;
                        maddr_d = addr_q;
                        state_d = WRITE;
                    end else begin
                        lo_d    = in_data;
                        state_d = HIGH;
                    end
                end
            end
            HIGH: begin
                if (accept) begin
                    wdata_d = {in_data, lo_q};
                    be_d    = BE_BOTH;
                    maddr_d = addr_q;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // Address arithmetic is ADDR_W wide, so the top word wraps to 0.
                addr_d  = addr_q + ADDR_W'(1);
                rem_d   = rem_q - ((be_q == BE_BOTH) ? LEN_W'(2) : LEN_W'(1));
                state_d = (rem_d == '0) ? DONE : LOW;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state implies,
        // so they line up with the state they describe.
        in_ready_d = (state_d == LOW) || (state_d == HIGH);
        wr_d       = (state_d == WRITE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            lo_q       <= '0;
            in_ready_q <= 1'b0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            maddr_q    <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            lo_q       <= lo_d;
            in_ready_q <= in_ready_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            maddr_q    <= maddr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign mem_write      = wr_q;
    assign mem_chipselect = wr_q;
    assign mem_address    = maddr_q;
    assign mem_byteenable = be_q;
    assign mem_writedata  = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_nios_system_byte_stream_loader.sv
// Self-checking bench for the byte-stream loader: random byte streams are
// turned into an expected list of memory writes by a simple arithmetic model
// and compared against writes captured from the write-master port.
module tb_nios_system_byte_stream_loader;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned LEN_W  = 15;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  length;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [1:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [15:0]       mem_writedata;
    logic              busy;
    logic              done;

    nios_system_byte_stream_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .start_addr     (start_addr),
        .length         (length),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [15:0]       d;
        logic [1:0]        be;
        int                c;
    } wr_t;

    wr_t        obs[$];
    wr_t        exp_q[$];
    logic [7:0] bytes[$];
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         cs_err   = 0;
    int         wide_err = 0;
    logic       prev_wr  = 1'b0;

    // Passive monitor: records every write strobe and done pulse.
    always @(negedge clk) begin
        if (mem_write)
            obs.push_back('{a: mem_address, d: mem_writedata, be: mem_byteenable, c: cyc});
        if (mem_chipselect !== mem_write) cs_err++;
        if (mem_write && prev_wr) wide_err++;
        prev_wr = mem_write;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Reference model: byte i goes to word (base + i/2) mod DEPTH, lane i%2.
    task automatic build_expected(input int base, input int len);
        wr_t w;
        exp_q.delete();
        for (int i = 0; i < len; i += 2) begin
            w.a = ADDR_W'((base + i / 2) % DEPTH);
            if (i + 1 < len) begin
                w.d  = 16'(bytes[i]) + 16'(bytes[i+1]) * 16'd256;
                w.be = 2'b11;
            end else begin
                w.d  = 16'(bytes[i]);
                w.be = 2'b01;
            end
            w.c = 0;
            exp_q.push_back(w);
        end
    endtask

    task automatic fill_random(input int len);
        bytes.delete();
        for (int i = 0; i < len; i++) bytes.push_back(8'($urandom));
    endtask

    // Called at a negedge; returns at the negedge following the start edge.
    task automatic pulse_start(input int a, input int l, output int sc);
        start      = 1'b1;
        start_addr = ADDR_W'(a);
        length     = LEN_W'(l);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        sc    = cyc;
    endtask

    // Feeds bytes[0..n-1]; entered and left at a negedge.
    task automatic feed(input string name, input int n, input bit gaps, input bit spurious);
        int idx = 0;
        bit acc;
        bit spur_done = 1'b0;
        for (int k = 0; k < 4000 && idx < n; k++) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? bytes[idx] : 8'($urandom);
            if (spurious && idx == 1 && !spur_done) begin
                start      = 1'b1;
                start_addr = ADDR_W'($urandom);
                length     = LEN_W'($urandom_range(1, 9));
                spur_done  = 1'b1;
            end else begin
                start = 1'b0;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        checks++;
        if (idx != n) begin
            errors++;
            $display("FAIL %s feed_timeout: accepted %0d bytes, required %0d", name, idx, n);
        end
    endtask

    task automatic wait_done(input string name, input int d0);
        for (int k = 0; k < 200 && done_cnt == d0; k++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL %s done_timeout: done pulses %0d, required %0d", name, done_cnt - d0, 1);
        end
    endtask

    // Full transfer using the current contents of bytes[].
    task automatic run_xfer(input string name, input int base, input int len,
                            input bit gaps, input bit spurious);
        int sc;
        int d0 = done_cnt;
        build_expected(base, len);
        obs.delete();
        @(negedge clk);
        pulse_start(base, len, sc);
        feed(name, len, gaps, spurious);
        wait_done(name, d0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after_done: got %b, required 0", name, busy);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d, required %0d", name, obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i].a !== exp_q[i].a || obs[i].d !== exp_q[i].d || obs[i].be !== exp_q[i].be) begin
                errors++;
                $display("FAIL %s write[%0d]: got a=%h d=%h be=%b, required a=%h d=%h be=%b", name, i,
                         obs[i].a, obs[i].d, obs[i].be, exp_q[i].a, exp_q[i].d, exp_q[i].be);
            end
        end
        checks++;
        if (obs.size() > 0 && done_cyc != obs[obs.size()-1].c + 1) begin
            errors++;
            $display("FAIL %s done_timing: done cycle %0d, required %0d", name, done_cyc, obs[obs.size()-1].c + 1);
        end
        checks++;
        if (done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL %s done_count: got %0d, required 1", name, done_cnt - d0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, mem_write, mem_chipselect, busy, done} !== 5'b0 ||
            mem_address !== '0 || mem_byteenable !== 2'b00 || mem_writedata !== 16'h0) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b wr=%b cs=%b busy=%b done=%b a=%h be=%b d=%h, required all 0",
                     in_ready, mem_write, mem_chipselect, busy, done, mem_address, mem_byteenable, mem_writedata);
        end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_xfer("b2b", 16'h0010, 4, 1'b0, 1'b0);
        checks++;
        if (obs.size() != 2 || obs[0].d !== 16'hBBAA || obs[1].d !== 16'hDDCC || obs[1].a !== 13'h0011) begin
            errors++;
            $display("FAIL b2b_words: got %0d writes, required 0010=BBAA 0011=DDCC", obs.size());
        end else begin
            checks++;
            if (obs[1].c - obs[0].c != 3) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d cycles, required 3", obs[1].c - obs[0].c);
            end
        end
        checks++;
        if (wide_err != 0) begin
            errors++;
            $display("FAIL strobe_width: got %0d multi-cycle strobes, required 0", wide_err);
        end
    endtask

    task automatic test_odd_length();
        bytes = '{8'h11, 8'h22, 8'h33};
        run_xfer("odd", 16'h0100, 3, 1'b0, 1'b0);
        checks++;
        if (obs.size() != 2 || obs[1].d !== 16'h0033 || obs[1].be !== 2'b01) begin
            errors++;
            $display("FAIL odd_tail: got %0d writes, required last 0101=0033 be=01", obs.size());
        end
    endtask

    task automatic test_wrap();
        fill_random(4);
        run_xfer("wrap", 16'h1FFF, 4, 1'b0, 1'b0);
        checks++;
        if (obs.size() != 2 || obs[0].a !== 13'h1FFF || obs[1].a !== 13'h0000) begin
            errors++;
            $display("FAIL wrap_addr: got %0d writes, required 1FFF then 0000", obs.size());
        end
    endtask

    task automatic test_zero_length();
        int sc;
        int d0 = done_cnt;
        obs.delete();
        @(negedge clk);
        pulse_start(100, 0, sc);
        #1;
        checks++;
        if (done_cnt != d0 + 1 || done_cyc != sc) begin
            errors++;
            $display("FAIL zero_done: done count %0d at cycle %0d, required 1 at cycle %0d", done_cnt - d0, done_cyc, sc);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_busy: got %b, required 0", busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (obs.size() != 0) begin
            errors++;
            $display("FAIL zero_nowrite: got %0d writes, required 0", obs.size());
        end
    endtask

    task automatic test_random_gaps();
        for (int t = 0; t < 8; t++) begin
            int len  = $urandom_range(2, 21);
            int base = $urandom_range(0, DEPTH - 1);
            fill_random(len);
            run_xfer($sformatf("gaps%0d", t), base, len, 1'b1, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        int sc;
        fill_random(4);
        obs.delete();
        @(negedge clk);
        pulse_start(16'h0200, 4, sc);
        feed("mid_first", 1, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, mem_write, mem_chipselect, busy, done} !== 5'b0 ||
            mem_address !== '0 || mem_byteenable !== 2'b00 || mem_writedata !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset_values: got rdy=%b wr=%b busy=%b done=%b a=%h be=%b d=%h, required all 0",
                     in_ready, mem_write, busy, done, mem_address, mem_byteenable, mem_writedata);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (obs.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_nowrite: got %0d writes, required 0", obs.size());
        end
        fill_random(5);
        run_xfer("after_reset", 16'h0300, 5, 1'b1, 1'b0);
    endtask

    task automatic test_chipselect();
        checks++;
        if (cs_err != 0) begin
            errors++;
            $display("FAIL chipselect_match: got %0d mismatched cycles, required 0", cs_err);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        in_data    = '0;
        in_valid   = 1'b0;
        test_reset();
        test_back_to_back();
        test_odd_length();
        test_wrap();
        test_zero_length();
        test_random_gaps();
        test_reset_mid();
        test_chipselect();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
